hash_collector: RTL and testbench



---
 rtl/hash_collector.sv | 130 +++++++++++++
 tb/tb_hash_collector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hash_collector.sv
// Reassembles the byte-serial Blake2 digest stream into parallel words and
// buffers completed digests in a 2-entry FIFO with a valid/ready handshake.
module hash_collector #(
    parameter int HASH_BYTES = 32,
    parameter int CNT_W      = 16,
    localparam int LEN_W     = $clog2(HASH_BYTES + 1),
    localparam int DIG_W     = 8 * HASH_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hash_v_i,
    input  logic [7:0]       hash_i,
    output logic             digest_valid_o,
    input  logic             digest_ready_i,
    output logic [DIG_W-1:0] digest_o,
    output logic [LEN_W-1:0] digest_len_o,
    output logic [CNT_W-1:0] digest_cnt_o,
    output logic             overflow_o,
    output logic             too_long_o
);

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(HASH_BYTES);

    state_t           state_q, state_d;
    logic [DIG_W-1:0] asm_q;
    logic [LEN_W-1:0] cnt_q;
    logic [DIG_W-1:0] head_data_q, tail_data_q;
    logic [LEN_W-1:0] head_len_q, tail_len_q;
    logic [1:0]       occ_q;
    logic [CNT_W-1:0] dcnt_q;
    logic             ovf_q, tl_q;
    logic             commit, pop, push, at_max;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE:    if (hash_v_i) state_d = COLLECT;
            COLLECT: if (!hash_v_i) begin
                state_d = IDLE;
                commit  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A full FIFO can still take a commit when the head leaves on the same edge.
    assign pop    = (occ_q != 2'd0) && digest_ready_i;
    assign push   = commit && ((occ_q != 2'd2) || pop);
    assign at_max = (cnt_q == MAX_LEN);

    // Assembly stage: bytes land at index cnt_q; everything above stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q <= '0;
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            asm_q <= '0;
            cnt_q <= '0;
            if (hash_v_i) begin
                asm_q[7:0] <= hash_i;
                cnt_q      <= LEN_W'(1);
            end
        end else if (hash_v_i && !at_max) begin
            for (int k = 0; k < HASH_BYTES; k++) begin
                if (cnt_q == LEN_W'(k)) asm_q[8*k +: 8] <= hash_i;
            end
            cnt_q <= cnt_q + LEN_W'(1);
        end
    end

    // FIFO stage: head is a register so the outputs hold after the last pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q       <= '0;
            head_data_q <= '0;
            head_len_q  <= '0;
        end else begin
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
            case (occ_q)
                2'd0: if (push) begin
                    head_data_q <= asm_q;
                    head_len_q  <= cnt_q;
                end
                2'd1: if (push && pop) begin
                    head_data_q <= asm_q;
                    head_len_q  <= cnt_q;
                end
                default: if (pop) begin
                    head_data_q <= tail_data_q;
                    head_len_q  <= tail_len_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && ((occ_q == 2'd1 && !pop) || occ_q == 2'd2)) begin
            tail_data_q <= asm_q;
            tail_len_q  <= cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q <= '0;
            ovf_q  <= 1'b0;
            tl_q   <= 1'b0;
        end else begin
            if (push && (dcnt_q != '1)) dcnt_q <= dcnt_q + CNT_W'(1);
            if (commit && !push)        ovf_q  <= 1'b1;
            if (state_q == COLLECT && hash_v_i && at_max) tl_q <= 1'b1;
        end
    end

    assign digest_valid_o = (occ_q != 2'd0);
    assign digest_o       = head_data_q;
    assign digest_len_o   = head_len_q;
    assign digest_cnt_o   = dcnt_q;
    assign overflow_o     = ovf_q;
    assign too_long_o     = tl_q;

endmodule

// File: tb/tb_hash_collector.sv
// Bench for hash_collector: vector table, hand-written corner sequences and
// randomized traffic against a queue-based digest model.
module tb_hash_collector;

    localparam int HB = 32;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hash_v_i = 1'b0;
    logic [7:0]    hash_i = '0;
    logic          digest_ready_i = 1'b0;
    logic          digest_valid_o;
    logic [DW-1:0] digest_o;
    logic [5:0]    digest_len_o;
    logic [15:0]   digest_cnt_o;
    logic          overflow_o;
    logic          too_long_o;

    hash_collector #(.HASH_BYTES(HB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hash_v_i(hash_v_i), .hash_i(hash_i),
        .digest_valid_o(digest_valid_o), .digest_ready_i(digest_ready_i),
        .digest_o(digest_o), .digest_len_o(digest_len_o),
        .digest_cnt_o(digest_cnt_o), .overflow_o(overflow_o),
        .too_long_o(too_long_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: digests as byte lists and a FIFO of completed words.
    bit            m_coll;
    byte unsigned  m_cur[$];
    logic [DW-1:0] m_qd[$];
    int            m_ql[$];
    logic [DW-1:0] m_shown_d;
    int            m_shown_l;
    int            m_cnt;
    bit            m_ovf, m_tl;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [7:0] b, input bit rdy);
        bit            pop, acc;
        logic [DW-1:0] d;
        int            l;
        acc = 1'b0;
        d   = '0;
        l   = 0;
        if (r) begin
            m_coll = 0; m_cur.delete(); m_qd.delete(); m_ql.delete();
            m_shown_d = '0; m_shown_l = 0; m_cnt = 0; m_ovf = 0; m_tl = 0;
            return;
        end
        pop = (m_qd.size() > 0) && rdy;
        if (m_coll && !v) begin
            foreach (m_cur[k]) d[8*k +: 8] = m_cur[k];
            l   = m_cur.size();
            acc = (m_qd.size() < 2) || pop;
            if (acc && m_cnt < 65535) m_cnt++;
            if (!acc) m_ovf = 1;
            m_coll = 0;
            m_cur.delete();
        end else if (v) begin
            if (!m_coll) begin
                m_coll = 1;
                m_cur.push_back(b);
            end else if (m_cur.size() < HB) m_cur.push_back(b);
            else m_tl = 1;
        end
        if (pop) begin
            m_qd.delete(0);
            m_ql.delete(0);
        end
        if (acc) begin
            m_qd.push_back(d);
            m_ql.push_back(l);
        end
        if (m_qd.size() > 0) begin
            m_shown_d = m_qd[0];
            m_shown_l = m_ql[0];
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] b, input bit rdy);
        rst = r; hash_v_i = v; hash_i = b; digest_ready_i = rdy;
        @(posedge clk);
        model_edge(r, v, b, rdy);
        #1;
        check("mdl_valid", DW'(digest_valid_o), DW'(m_qd.size() > 0));
        check("mdl_digest", digest_o, m_shown_d);
        check("mdl_len", DW'(digest_len_o), DW'(m_shown_l));
        check("mdl_cnt", DW'(digest_cnt_o), DW'(m_cnt));
        check("mdl_overflow", DW'(overflow_o), DW'(m_ovf));
        check("mdl_too_long", DW'(too_long_o), DW'(m_tl));
    endtask

    task automatic send(input int n, input logic [7:0] first, input bit inc,
                        input bit rdy, input bit rdy_commit);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, inc ? 8'(first + i) : first, rdy);
        step(1'b0, 1'b0, 8'h00, rdy_commit);
    endtask

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        logic [DW-1:0] d;
        for (int k = 0; k < HB; k++) d[8*k +: 8] = b;
        return d;
    endfunction

    typedef struct {
        int         n;
        logic [7:0] first;
        int         exp_len;
        bit         exp_tl;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [DW-1:0] e;
        tbl[0] = '{32, 8'h00, 32, 1'b0, 1};
        tbl[1] = '{16, 8'hA0, 16, 1'b0, 2};
        tbl[2] = '{ 1, 8'h5A,  1, 1'b0, 3};
        tbl[3] = '{31, 8'h40, 31, 1'b0, 4};
        tbl[4] = '{40, 8'h00, 32, 1'b1, 5};

        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_valid", DW'(digest_valid_o), '0);
        check("rst_digest", digest_o, '0);
        check("rst_len", DW'(digest_len_o), '0);
        check("rst_cnt", DW'(digest_cnt_o), '0);
        check("rst_flags", DW'({overflow_o, too_long_o}), '0);

        foreach (tbl[t]) begin
            send(tbl[t].n, tbl[t].first, 1'b1, 1'b1, 1'b1);
            e = '0;
            for (int k = 0; k < tbl[t].exp_len; k++) e[8*k +: 8] = 8'(tbl[t].first + k);
            check("tbl_valid", DW'(digest_valid_o), DW'(1));
            check("tbl_digest", digest_o, e);
            check("tbl_len", DW'(digest_len_o), DW'(tbl[t].exp_len));
            check("tbl_cnt", DW'(digest_cnt_o), DW'(tbl[t].exp_cnt));
            check("tbl_too_long", DW'(too_long_o), DW'(tbl[t].exp_tl));
            step(1'b0, 1'b0, 8'h00, 1'b1);
            check("tbl_pulse", DW'(digest_valid_o), '0);
        end

        // Overflow with consumer stalled, then drain.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(32, 8'h11, 1'b0, 1'b0, 1'b0);
        send(32, 8'h22, 1'b0, 1'b0, 1'b0);
        send(32, 8'h33, 1'b0, 1'b0, 1'b0);
        check("ovf_flag", DW'(overflow_o), DW'(1));
        check("ovf_cnt", DW'(digest_cnt_o), DW'(2));
        check("ovf_head0", digest_o, rep(8'h11));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_head1", digest_o, rep(8'h22));
        check("ovf_valid1", DW'(digest_valid_o), DW'(1));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_empty", DW'(digest_valid_o), '0);

        // Full FIFO with a pop on the commit edge.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(32, 8'h11, 1'b0, 1'b0, 1'b0);
        send(32, 8'h22, 1'b0, 1'b0, 1'b0);
        send(32, 8'h33, 1'b0, 1'b0, 1'b1);
        check("sim_ovf", DW'(overflow_o), '0);
        check("sim_cnt", DW'(digest_cnt_o), DW'(3));
        check("sim_head0", digest_o, rep(8'h22));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("sim_head1", digest_o, rep(8'h33));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("sim_empty", DW'(digest_valid_o), '0);

        // Reset in the middle of a digest with one entry queued.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(32, 8'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h55, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        check("mid_valid", DW'(digest_valid_o), '0);
        check("mid_digest", digest_o, '0);
        check("mid_len_cnt", DW'({digest_len_o, digest_cnt_o}), '0);
        check("mid_flags", DW'({overflow_o, too_long_o}), '0);
        step(1'b0, 1'b1, 8'hDE, 1'b0);
        step(1'b0, 1'b1, 8'hAD, 1'b0);
        step(1'b0, 1'b1, 8'hBE, 1'b0);
        step(1'b0, 1'b1, 8'hEF, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("fresh_valid", DW'(digest_valid_o), DW'(1));
        check("fresh_digest", digest_o, DW'(32'hEFBEADDE));
        check("fresh_len", DW'(digest_len_o), DW'(4));
        check("fresh_cnt", DW'(digest_cnt_o), DW'(1));

        // Randomized traffic: varied lengths, gaps, ready duty and rare resets.
        for (int d = 0; d < 40; d++) begin
            int n, gap, bias;
            n    = $urandom_range(1, 36);
            gap  = $urandom_range(0, 2);
            bias = $urandom_range(0, 4);
            for (int i = 0; i < n; i++)
                step(($urandom % 150) == 0, 1'b1, 8'($urandom), $urandom_range(0, 3) < bias);
            step(1'b0, 1'b0, 8'h00, $urandom_range(0, 3) < bias);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'h00, $urandom_range(0, 3) < bias);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
